// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
// Optional LOADER_CHECKSUM_EN adds a trailing XOR checksum byte to the image.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_IMEM,
        ST_DMEM,
        ST_FIN,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int   HDR_BYTES    = 4;
    localparam logic MEM_SEL_IMEM = 1'b0;
    localparam logic MEM_SEL_DMEM = 1'b1;

endpackage

// File: rtl/uart_prog_loader_if.sv
// Memory write port driven by the loader towards imem/dmem.
// One-cycle mem_we strobe; mem_sel picks the target memory.
interface uart_prog_loader_if;
    logic        mem_we;
    logic        mem_sel;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (output mem_we, output mem_sel, output mem_addr, output mem_wdata);
    modport slave  (input  mem_we, input  mem_sel, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/uart_prog_loader_uart_rx_core.sv
// 8N1 UART receiver, LSB first; input must already be synchronised.
// byte_valid/frame_err pulse one cycle after the stop-bit sample; no backpressure.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_sync,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          vld_q, vld_d;
    logic          ferr_q, ferr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            vld_q   <= vld_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        sh_d    = sh_q;
        vld_d   = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_sync) state_d = RX_START;
            end
            RX_START: begin
                // a low pulse shorter than half a bit is treated as a glitch
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d = '0;
                    sh_d  = {rx_sync, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    vld_d   = rx_sync;
                    ferr_d  = ~rx_sync;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_data  = sh_q;
    assign byte_valid = vld_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_prog_loader.sv
// Loads a UART image into imem then dmem while holding the CPU in reset.
// Writes one cycle after each 4th byte; no backpressure. LOADER_CHECKSUM_EN adds a trailing XOR byte.
module uart_prog_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 868,
    parameter int IMEM_WORDS     = 16384,
    parameter int DMEM_WORDS     = 16384,
    parameter int TIMEOUT_CYCLES = 10000000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_pg,
    input  logic                       rx,
    output logic                       cpu_rst_n,
    output logic                       loading,
    output logic                       done,
    output logic                       err,
    uart_prog_loader_if.master         mem
);

    localparam logic [31:0] TO_LIM    = 32'(TIMEOUT_CYCLES);
    localparam logic [31:0] IMEM_LIM  = 32'(IMEM_WORDS);
    localparam logic [31:0] DMEM_LIM  = 32'(DMEM_WORDS);
    localparam logic [1:0]  LAST_BYTE = 2'(HDR_BYTES - 1);

    logic [1:0] start_s_q, rx_s_q;
    logic       start_prev_q;
    logic [7:0] byte_data;
    logic       byte_valid, frame_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_s_q    <= 2'b00;
            rx_s_q       <= 2'b11;
            start_prev_q <= 1'b0;
        end else begin
            start_s_q    <= {start_s_q[0], start_pg};
            rx_s_q       <= {rx_s_q[0], rx};
            start_prev_q <= start_s_q[1];
        end
    end

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_sync    (rx_s_q[1]),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    state_t      state_q, state_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [31:0] asm_q, asm_d;
    logic [15:0] icnt_q, icnt_d, dcnt_q, dcnt_d;
    logic [15:0] widx_q, widx_d;
    logic [31:0] idle_q, idle_d;
    logic        we_q, we_d, sel_q, sel_d;
    logic [13:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bcnt_q  <= '0;
            asm_q   <= '0;
            icnt_q  <= '0;
            dcnt_q  <= '0;
            widx_q  <= '0;
            idle_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= MEM_SEL_IMEM;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            icnt_q  <= icnt_d;
            dcnt_q  <= dcnt_d;
            widx_q  <= widx_d;
            idle_q  <= idle_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    logic        start_edge, timeout;
    logic [15:0] tgt_cnt;

    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        asm_d      = asm_q;
        icnt_d     = icnt_q;
        dcnt_d     = dcnt_q;
        widx_d     = widx_q;
        idle_d     = byte_valid ? 32'd0 : idle_q + 32'd1;
        we_d       = 1'b0;
        sel_d      = sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        start_edge = start_s_q[1] & ~start_prev_q;
        timeout    = (idle_q + 32'd1) >= TO_LIM;
        tgt_cnt    = (state_q == ST_IMEM) ? icnt_q : dcnt_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = byte_valid ? (csum_q ^ byte_data) : csum_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                idle_d = '0;
                if (start_edge) begin
                    state_d = ST_HDR;
                    bcnt_d  = '0;
                    widx_d  = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            ST_HDR: begin
                if (frame_err) begin
                    state_d = ST_ERR;
                end else if (byte_valid) begin
                    asm_d  = {byte_data, asm_q[31:8]};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == LAST_BYTE) begin
                        icnt_d = asm_d[15:0];
                        dcnt_d = asm_d[31:16];
                        if ({16'd0, asm_d[15:0]} > IMEM_LIM || {16'd0, asm_d[31:16]} > DMEM_LIM)
                            state_d = ST_ERR;
                        else if (asm_d[15:0] != 16'd0)
                            state_d = ST_IMEM;
                        else if (asm_d[31:16] != 16'd0)
                            state_d = ST_DMEM;
                        else
                            state_d = ST_FIN;
                    end
                end else if (timeout) begin
                    state_d = ST_ERR;
                end
            end
            ST_IMEM, ST_DMEM: begin
                if (frame_err) begin
                    state_d = ST_ERR;
                end else if (byte_valid) begin
                    asm_d  = {byte_data, asm_q[31:8]};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == LAST_BYTE) begin
                        we_d    = 1'b1;
                        wdata_d = asm_d;
                        addr_d  = widx_q[13:0];
                        sel_d   = (state_q == ST_DMEM) ? MEM_SEL_DMEM : MEM_SEL_IMEM;
                        widx_d  = widx_q + 16'd1;
                        if (widx_q + 16'd1 == tgt_cnt) begin
                            widx_d = '0;
                            if (state_q == ST_IMEM && dcnt_q != 16'd0)
                                state_d = ST_DMEM;
                            else
                                state_d = ST_FIN;
                        end
                    end
                end else if (timeout) begin
                    state_d = ST_ERR;
                end
            end
            ST_FIN: begin
`ifdef LOADER_CHECKSUM_EN
                if (frame_err)
                    state_d = ST_ERR;
                else if (byte_valid)
                    state_d = (byte_data == csum_q) ? ST_DONE : ST_ERR;
                else if (timeout)
                    state_d = ST_ERR;
`else
                idle_d  = '0;
                state_d = ST_DONE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign loading       = (state_q == ST_HDR) || (state_q == ST_IMEM) ||
                           (state_q == ST_DMEM) || (state_q == ST_FIN);
    assign done          = (state_q == ST_DONE);
    assign err           = (state_q == ST_ERR);
    assign cpu_rst_n     = ~(loading || err);
    assign mem.mem_we    = we_q;
    assign mem.mem_sel   = sel_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench: expected memory writes are queued as bytes are sent and a monitor pops them on each mem_we.
module tb_uart_prog_loader;

    localparam int CPB = 16;

    logic clk = 1'b0, rst_n = 1'b0, start_pg = 1'b0, rx = 1'b1;
    logic cpu_rst_n, loading, done, err;

    uart_prog_loader_if mem_if();

    uart_prog_loader #(
        .CLKS_PER_BIT(CPB), .IMEM_WORDS(16384), .DMEM_WORDS(16384), .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_pg  (start_pg),
        .rx        (rx),
        .cpu_rst_n (cpu_rst_n),
        .loading   (loading),
        .done      (done),
        .err       (err),
        .mem       (mem_if.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sel;
        logic [13:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] tb_xor  = 8'h00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // monitor: every write strobe must match the oldest queued expectation
    wr_t got_w, exp_w;
    always @(negedge clk) begin
        if (rst_n && mem_if.mem_we === 1'b1) begin
            got_w = '{mem_if.mem_sel, mem_if.mem_addr, mem_if.mem_wdata};
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got %0h, expected no write", got_w);
            end else begin
                exp_w = sb.pop_front();
                check("mem_write", 64'(got_w), 64'(exp_w));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        tb_xor = tb_xor ^ b;
        @(negedge clk) rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic send_hdr(input logic [15:0] ic, input logic [15:0] dc);
        send_word({dc, ic});
    endtask

    task automatic send_csum();
`ifdef LOADER_CHECKSUM_EN
        send_byte(tb_xor, 1'b1);
`endif
    endtask

    task automatic press_start();
        @(negedge clk) start_pg = 1'b1;
        repeat (4) @(negedge clk);
        start_pg = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic start_load();
        tb_xor = 8'h00;
        press_start();
    endtask

    task automatic expect_wr(input logic sel, input logic [13:0] addr, input logic [31:0] data);
        sb.push_back('{sel, addr, data});
    endtask

    task automatic wait_end(input string name);
        int n = 0;
        while (!(done || err) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (!(done || err)) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got no done/err, expected completion within 4000 cycles", name);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected end of run");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_status", {cpu_rst_n, loading, done, err}, 4'b1000);
        check("rst_mem", {mem_if.mem_we, mem_if.mem_sel, mem_if.mem_addr, mem_if.mem_wdata}, 48'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // normal load: 2 imem words, 1 dmem word; a start press mid-load is ignored
        start_load();
        check("a_loading", {loading, cpu_rst_n}, 2'b10);
        expect_wr(1'b0, 14'd0, 32'h00500093);
        expect_wr(1'b0, 14'd1, 32'h00100113);
        expect_wr(1'b1, 14'd0, 32'hDEADBEEF);
        send_hdr(16'd2, 16'd1);
        press_start();
        check("a_start_ignored", {loading, err}, 2'b10);
        send_word(32'h00500093);
        send_word(32'h00100113);
        send_word(32'hDEADBEEF);
        send_csum();
        wait_end("a_wait");
        check("a_done", {done, err, cpu_rst_n, loading}, 4'b1010);
        check("a_sb_empty", sb.size(), 0);

        // empty image
        start_load();
        check("b_done_cleared", {done, loading}, 2'b01);
        send_hdr(16'd0, 16'd0);
        send_csum();
        wait_end("b_wait");
        check("b_done", {done, err, cpu_rst_n}, 3'b101);

        // imem count above depth
        start_load();
        send_hdr(16'h4001, 16'd0);
        check("c_err", {err, done, loading, cpu_rst_n}, 4'b1000);
        repeat (50) @(negedge clk);
        check("c_err_held", {err, cpu_rst_n}, 2'b10);

        // framing error inside the first word
        start_load();
        send_hdr(16'd1, 16'd0);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        repeat (400) @(negedge clk);
        check("d_err", {err, loading, cpu_rst_n}, 3'b100);
        check("d_sb_empty", sb.size(), 0);

        // stall after two bytes of a word, then recover
        start_load();
        send_hdr(16'd1, 16'd0);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        repeat (900) @(negedge clk);
        check("e_not_yet", {err, loading}, 2'b01);
        repeat (200) @(negedge clk);
        check("e_timeout", {err, loading, cpu_rst_n}, 3'b100);
        start_load();
        expect_wr(1'b0, 14'd0, 32'h12345678);
        send_hdr(16'd1, 16'd0);
        send_word(32'h12345678);
        send_csum();
        wait_end("e_wait");
        check("e_recover", {done, err, cpu_rst_n}, 3'b101);

        // asynchronous reset mid-load
        start_load();
        expect_wr(1'b0, 14'd0, 32'hCAFEF00D);
        send_hdr(16'd2, 16'd0);
        send_word(32'hCAFEF00D);
        send_byte(8'h01, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("f_rst_status", {cpu_rst_n, loading, done, err}, 4'b1000);
        check("f_rst_mem", {mem_if.mem_we, mem_if.mem_sel, mem_if.mem_addr, mem_if.mem_wdata}, 48'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        check("f_idle", {loading, done, err, cpu_rst_n}, 4'b0001);
        check("f_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
